// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - turns a debounced button level into press/release/long/repeat strobes
module button_event_ctrl #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_WIDTH     = 32,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_debounc,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] repeat_count
);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD, REPEAT} state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 btn_prev_q, btn_prev_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;
  logic                 repeat_q, repeat_d;
  logic                 held_q, held_d;
  logic [7:0]           rep_cnt_q, rep_cnt_d;
  logic                 rise;

  assign rise = btn_debounc & ~btn_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    btn_prev_d = btn_debounc;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    rep_cnt_d  = rep_cnt_q;
    // Disabling aborts any hold silently; repeat_count survives until the next press.
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            press_d   = 1'b1;
            cnt_d     = '0;
            rep_cnt_d = 8'd0;
            state_d   = PRESS;
          end
        end
        PRESS: begin
          if (!btn_debounc) begin
            release_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else if (cnt_q == LONG_TC) begin
            long_d  = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT_EN ? REPEAT : HOLD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HOLD: begin
          if (!btn_debounc) begin
            release_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
        REPEAT: begin
          // Release is tested first so it wins over a coincident terminal count.
          if (!btn_debounc) begin
            release_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else if (cnt_q == REPEAT_TC) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
            if (rep_cnt_q != 8'hFF) rep_cnt_d = rep_cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      btn_prev_q <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
      rep_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      held_q     <= held_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign repeat_count  = rep_cnt_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - directed bench for button_event_ctrl (dut0 with repeat, dut1 without)
module tb_button_event_ctrl;

  logic clk = 1'b0;
  logic reset, enable, btn;
  logic p0, r0, l0, rp0, h0;
  logic p1, r1, l1, rp1, h1;
  logic [7:0] rc0, rc1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_press [2];
  int n_rel   [2];
  int n_long  [2];
  int n_rep   [2];
  int long_cyc[2];
  int press_cyc[2];
  int multi   [2];
  int rep_cyc [$];

  always #5 clk = ~clk;

  button_event_ctrl #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_WIDTH(8), .REPEAT_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .btn_debounc(btn),
    .press_pulse(p0), .release_pulse(r0), .long_pulse(l0), .repeat_pulse(rp0),
    .held(h0), .repeat_count(rc0)
  );

  button_event_ctrl #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_WIDTH(8), .REPEAT_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .btn_debounc(btn),
    .press_pulse(p1), .release_pulse(r1), .long_pulse(l1), .repeat_pulse(rp1),
    .held(h1), .repeat_count(rc1)
  );

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rep[i] = 0;
      long_cyc[i] = -1; press_cyc[i] = -1; multi[i] = 0;
    end
    rep_cyc.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (p0)  begin n_press[0]++; press_cyc[0] = cyc; end
    if (r0)  n_rel[0]++;
    if (l0)  begin n_long[0]++; long_cyc[0] = cyc; end
    if (rp0) begin n_rep[0]++; rep_cyc.push_back(cyc); end
    if (int'(p0) + int'(r0) + int'(l0) + int'(rp0) > 1) multi[0]++;
    if (p1)  begin n_press[1]++; press_cyc[1] = cyc; end
    if (r1)  n_rel[1]++;
    if (l1)  begin n_long[1]++; long_cyc[1] = cyc; end
    if (rp1) n_rep[1]++;
    if (int'(p1) + int'(r1) + int'(l1) + int'(rp1) > 1) multi[1]++;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; btn = 1'b1;
    repeat (3) step();
    checks++;
    if ({p0, r0, l0, rp0, h0} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {p0, r0, l0, rp0, h0});
    end
    checks++;
    if (rc0 !== 8'd0) begin errors++; $display("FAIL reset_repeat_count: got %0d want 0", rc0); end
    reset = 1'b1;
    clear_stats();
    repeat (20) step();
    checks++;
    if (n_press[0] + n_rel[0] + n_long[0] + n_rep[0] != 0) begin
      errors++; $display("FAIL held_through_reset_pulses: got %0d want 0", n_press[0] + n_rel[0] + n_long[0] + n_rep[0]);
    end
    checks++;
    if (h0 !== 1'b0) begin errors++; $display("FAIL held_through_reset_held: got %b want 0", h0); end
    btn = 1'b0; step();
    btn = 1'b1; step();
    checks++;
    if (p0 !== 1'b1) begin errors++; $display("FAIL first_press: got %b want 1", p0); end
    step();
    checks++;
    if (p0 !== 1'b0 || h0 !== 1'b1 || n_press[0] != 1) begin
      errors++; $display("FAIL press_one_cycle: press=%b held=%b count=%0d want 0 1 1", p0, h0, n_press[0]);
    end
    btn = 1'b0; step(); step();
    checks++;
    if (h0 !== 1'b0) begin errors++; $display("FAIL first_release_held: got %b want 0", h0); end
  endtask

  task automatic test_short_press();
    clear_stats();
    btn = 1'b1;
    repeat (5) step();
    btn = 1'b0;
    step();
    checks++;
    if (r0 !== 1'b1) begin errors++; $display("FAIL short_release: got %b want 1", r0); end
    step();
    checks++;
    if (h0 !== 1'b0) begin errors++; $display("FAIL short_held_after: got %b want 0", h0); end
    checks++;
    if (n_press[0] != 1 || n_rel[0] != 1 || n_long[0] != 0 || n_rep[0] != 0) begin
      errors++; $display("FAIL short_counts: press=%0d rel=%0d long=%0d rep=%0d want 1 1 0 0",
                         n_press[0], n_rel[0], n_long[0], n_rep[0]);
    end
  endtask

  task automatic test_long_repeat();
    clear_stats();
    btn = 1'b1;
    repeat (30) step();
    checks++;
    if (n_long[0] != 1 || long_cyc[0] != press_cyc[0] + 8) begin
      errors++; $display("FAIL long_timing: count=%0d offset=%0d want 1 8", n_long[0], long_cyc[0] - press_cyc[0]);
    end
    checks++;
    if (rep_cyc.size() != 5) begin
      errors++; $display("FAIL repeat_count_strobes: got %0d want 5", rep_cyc.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (rep_cyc[k] != press_cyc[0] + 12 + 4 * k) begin
          errors++; $display("FAIL repeat_timing_%0d: offset %0d want %0d", k, rep_cyc[k] - press_cyc[0], 12 + 4 * k);
        end
      end
    end
    checks++;
    if (rc0 !== 8'd5) begin errors++; $display("FAIL repeat_count_value: got %0d want 5", rc0); end
    btn = 1'b0;
    step();
    checks++;
    if (r0 !== 1'b1 || rp0 !== 1'b0) begin
      errors++; $display("FAIL long_release: rel=%b rep=%b want 1 0", r0, rp0);
    end
    step();
    checks++;
    if (h0 !== 1'b0 || rc0 !== 8'd5) begin
      errors++; $display("FAIL long_after_release: held=%b rc=%0d want 0 5", h0, rc0);
    end
    checks++;
    if (multi[0] != 0) begin errors++; $display("FAIL one_hot_pulses: got %0d overlaps want 0", multi[0]); end
  endtask

  task automatic test_release_at_terminal();
    clear_stats();
    btn = 1'b1;
    repeat (8) step();
    btn = 1'b0;
    step();
    checks++;
    if (r0 !== 1'b1 || l0 !== 1'b0) begin
      errors++; $display("FAIL terminal_release: rel=%b long=%b want 1 0", r0, l0);
    end
    step();
    checks++;
    if (n_long[0] != 0 || n_rel[0] != 1) begin
      errors++; $display("FAIL terminal_counts: long=%0d rel=%0d want 0 1", n_long[0], n_rel[0]);
    end
  endtask

  task automatic test_no_repeat();
    clear_stats();
    btn = 1'b1;
    repeat (40) step();
    checks++;
    if (n_long[1] != 1 || long_cyc[1] != press_cyc[1] + 8) begin
      errors++; $display("FAIL norep_long: count=%0d offset=%0d want 1 8", n_long[1], long_cyc[1] - press_cyc[1]);
    end
    checks++;
    if (n_rep[1] != 0 || h1 !== 1'b1 || rc1 !== 8'd0) begin
      errors++; $display("FAIL norep_hold: rep=%0d held=%b rc=%0d want 0 1 0", n_rep[1], h1, rc1);
    end
    btn = 1'b0;
    step();
    checks++;
    if (r1 !== 1'b1) begin errors++; $display("FAIL norep_release: got %b want 1", r1); end
    step();
    checks++;
    if (h1 !== 1'b0) begin errors++; $display("FAIL norep_held_after: got %b want 0", h1); end
  endtask

  task automatic test_enable_drop();
    clear_stats();
    btn = 1'b1;
    repeat (14) step();
    checks++;
    if (rc0 !== 8'd1 || h0 !== 1'b1) begin
      errors++; $display("FAIL pre_drop: rc=%0d held=%b want 1 1", rc0, h0);
    end
    enable = 1'b0;
    step();
    checks++;
    if (h0 !== 1'b0 || {p0, r0, l0, rp0} !== 4'b0 || n_rel[0] != 0) begin
      errors++; $display("FAIL drop_enable: held=%b pulses=%b rel=%0d want 0 0000 0", h0, {p0, r0, l0, rp0}, n_rel[0]);
    end
    checks++;
    if (rc0 !== 8'd1) begin errors++; $display("FAIL drop_keeps_count: got %0d want 1", rc0); end
    enable = 1'b1;
    repeat (5) step();
    checks++;
    if (n_press[0] != 1 || h0 !== 1'b0) begin
      errors++; $display("FAIL reenable_no_press: press=%0d held=%b want 1 0", n_press[0], h0);
    end
    btn = 1'b0; step();
    btn = 1'b1; step();
    checks++;
    if (p0 !== 1'b1 || rc0 !== 8'd0) begin
      errors++; $display("FAIL repress: press=%b rc=%0d want 1 0", p0, rc0);
    end
    repeat (13) step();
    checks++;
    if (rc0 !== 8'd1 || h0 !== 1'b1) begin
      errors++; $display("FAIL pre_async: rc=%0d held=%b want 1 1", rc0, h0);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({p0, r0, l0, rp0, h0, h1} !== 6'b0 || rc0 !== 8'd0) begin
      errors++; $display("FAIL async_reset: outs=%b rc=%0d want 000000 0", {p0, r0, l0, rp0, h0, h1}, rc0);
    end
    reset = 1'b1;
    step();
    checks++;
    if (p0 !== 1'b0 || h0 !== 1'b0) begin
      errors++; $display("FAIL post_async_no_press: press=%b held=%b want 0 0", p0, h0);
    end
    btn = 1'b0;
    step();
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_at_terminal();
    test_no_repeat();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
